// File: rtl/pong_match_ctrl.sv
// Match/score controller for pong: sequences idle/serve/play/point/pause/over,
// keeps per-side BCD scores with binary shadows, and gates ball/paddle motion.
module pong_match_ctrl #(
  parameter int unsigned SCORE_DIGITS = 2,
  parameter int unsigned WIN_SCORE    = 11,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned SERVE_DELAY  = 50,
  parameter int unsigned POINT_DELAY  = 25
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      frame_tick_i,
  input  logic                      start_i,
  input  logic                      pause_i,
  input  logic                      miss_left_i,
  input  logic                      miss_right_i,
  output logic [4*SCORE_DIGITS-1:0] score_left_o,
  output logic [4*SCORE_DIGITS-1:0] score_right_o,
  output logic                      ball_enable_o,
  output logic                      ball_reset_o,
  output logic                      serve_dir_o,
  output logic [1:0]                winner_o,
  output logic [2:0]                state_o
);

  localparam int unsigned SW = 4 * SCORE_DIGITS;
  localparam logic [CNT_W-1:0] CntMax   = '1;
  localparam logic [CNT_W-1:0] WinCnt   = CNT_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0] ServeCnt = CNT_W'(SERVE_DELAY);
  localparam logic [CNT_W-1:0] PointCnt = CNT_W'(POINT_DELAY);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StServe  = 3'd1,
    StPlay   = 3'd2,
    StPoint  = 3'd3,
    StPaused = 3'd4,
    StOver   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shadow_l_q, shadow_l_d, shadow_r_q, shadow_r_d;
  logic [SW-1:0]    bcd_l_q, bcd_l_d, bcd_r_q, bcd_r_d;
  logic             ball_enable_q, ball_enable_d;
  logic             ball_reset_q, ball_reset_d;
  logic             serve_dir_q, serve_dir_d;
  logic [1:0]       winner_q, winner_d;
  logic             start_q, pause_q;
  logic             start_edge, pause_edge;

  assign start_edge = start_i & ~start_q;
  assign pause_edge = pause_i & ~pause_q;

  // BCD increment with per-digit carry; an all-nines score holds.
  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          carry;
    logic          all9;
    r     = v;
    carry = 1'b1;
    all9  = 1'b1;
    for (int i = 0; i < int'(SCORE_DIGITS); i++) begin
      if (v[4*i +: 4] != 4'd9) all9 = 1'b0;
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return all9 ? v : r;
  endfunction

  // Binary shadow increment that saturates at the counter maximum.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CntMax) ? v : v + CntOne;
  endfunction

  // Next-state, scoring and registered-output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shadow_l_d   = shadow_l_q;
    shadow_r_d   = shadow_r_q;
    bcd_l_d      = bcd_l_q;
    bcd_r_d      = bcd_r_q;
    serve_dir_d  = serve_dir_q;
    winner_d     = winner_q;
    ball_reset_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d      = StServe;
          cnt_d        = '0;
          shadow_l_d   = '0;
          shadow_r_d   = '0;
          bcd_l_d      = '0;
          bcd_r_d      = '0;
          winner_d     = 2'b00;
          serve_dir_d  = 1'b1;
          ball_reset_d = 1'b1;
        end
      end
      StServe: begin
        if (cnt_q == ServeCnt) begin
          state_d = StPlay;
          cnt_d   = '0;
        end else if (frame_tick_i) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StPlay: begin
        // Misses win over a simultaneous pause edge.
        if (miss_left_i && miss_right_i) begin
          state_d      = StServe;
          cnt_d        = '0;
          ball_reset_d = 1'b1;
        end else if (miss_right_i) begin
          shadow_l_d  = sat_inc(shadow_l_q);
          bcd_l_d     = bcd_inc(bcd_l_q);
          serve_dir_d = 1'b1;
          cnt_d       = '0;
          state_d     = StPoint;
        end else if (miss_left_i) begin
          shadow_r_d  = sat_inc(shadow_r_q);
          bcd_r_d     = bcd_inc(bcd_r_q);
          serve_dir_d = 1'b0;
          cnt_d       = '0;
          state_d     = StPoint;
        end else if (pause_edge) begin
          state_d = StPaused;
        end
      end
      StPaused: begin
        if (start_edge) begin
          state_d = StIdle;
        end else if (pause_edge) begin
          state_d = StPlay;
        end
      end
      StPoint: begin
        if (cnt_q == PointCnt) begin
          cnt_d = '0;
          if (shadow_l_q == WinCnt) begin
            state_d  = StOver;
            winner_d = 2'b01;
          end else if (shadow_r_q == WinCnt) begin
            state_d  = StOver;
            winner_d = 2'b10;
          end else begin
            state_d      = StServe;
            ball_reset_d = 1'b1;
          end
        end else if (frame_tick_i) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StOver: begin
        if (start_edge) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    ball_enable_d = (state_d == StPlay);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      shadow_l_q    <= '0;
      shadow_r_q    <= '0;
      bcd_l_q       <= '0;
      bcd_r_q       <= '0;
      ball_enable_q <= 1'b0;
      ball_reset_q  <= 1'b0;
      serve_dir_q   <= 1'b1;
      winner_q      <= 2'b00;
      start_q       <= 1'b0;
      pause_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shadow_l_q    <= shadow_l_d;
      shadow_r_q    <= shadow_r_d;
      bcd_l_q       <= bcd_l_d;
      bcd_r_q       <= bcd_r_d;
      ball_enable_q <= ball_enable_d;
      ball_reset_q  <= ball_reset_d;
      serve_dir_q   <= serve_dir_d;
      winner_q      <= winner_d;
      start_q       <= start_i;
      pause_q       <= pause_i;
    end
  end

  assign score_left_o  = bcd_l_q;
  assign score_right_o = bcd_r_q;
  assign ball_enable_o = ball_enable_q;
  assign ball_reset_o  = ball_reset_q;
  assign serve_dir_o   = serve_dir_q;
  assign winner_o      = winner_q;
  assign state_o       = state_q;

endmodule
